sopc_be_mem_stream_master: RTL and testbench
============================================

Name: sopc_be_mem_stream_master

Overview:
Avalon-MM style initiator that drives the single-port on-chip memory slave of the sopc_be system. Each command moves a block of 32-bit words in one of two directions. Read-out mode streams memory words to a valid/ready source port. Write-in mode accepts words from a valid/ready sink port and writes them to memory. It is the master-side counterpart of the on-chip memory and bridges memory-mapped storage to streaming logic.

Parameters:
DEPTH, 10000, memory depth in 32-bit words; addresses wrap modulo DEPTH
ADDR_W, 14, word-address width
DATA_W, 32, data width; byteenable width = DATA_W/8

Ports:
clk  in  1  single system clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  command strobe; sampled only in IDLE
mode  in  1  0 = read-out (mem->src), 1 = write-in (snk->mem)
base_addr  in  ADDR_W  first word address
length  in  ADDR_W  word count, 0..DEPTH
busy  out  1  high from accepted start until the DONE cycle
done  out  1  one-cycle pulse at command end
mem_address  out  ADDR_W  word address to memory
mem_chipselect  out  1  memory access strobe
mem_write  out  1  1 = write, 0 = read (valid with chipselect)
mem_byteenable  out  DATA_W/8  always all-ones
mem_writedata  out  DATA_W  write data
mem_clken  out  1  memory clock enable
mem_readdata  in  DATA_W  read data, fixed latency 1
src_data  out  DATA_W  streamed read data
src_valid  out  1  src_data valid
src_ready  in  1  downstream accept
snk_data  in  DATA_W  data to be written
snk_valid  in  1  snk_data valid
snk_ready  out  1  block accepts snk beat
csum  out  32  see Optional Feature

Behaviour:
- Reset values (asynchronous, immediate on reset_n low):
  - all outputs 0 except mem_clken = 0 and mem_byteenable = all-ones;
  - state IDLE;
  - FIFO emptied; counters cleared;
  - mem_clken rises to 1 on the first clk edge after reset release and then stays 1.
- States: IDLE, RD_RUN, RD_DRAIN, WR_RUN, WR_LAST, DONE.
- IDLE:
  - start=1 latches base_addr, length and mode; busy=1 from the next cycle.
  - length=0 -> DONE; no memory access.
  - mode=0 -> RD_RUN; mode=1 -> WR_RUN.
  - base_addr >= DEPTH is treated as 0; length > DEPTH is clamped to DEPTH.
- start outside IDLE is ignored and has no effect.
- Address increment: next = (addr == DEPTH-1) ? 0 : addr+1.
- RD_RUN:
  - A read issued in cycle t (chipselect=1, write=0) returns mem_readdata, which is captured at the end of cycle t+1 into a 2-entry FIFO that feeds src.
  - Issue condition: remaining > 0 and (fifo_count + inflight - pop) < 2.
  - Sustains 1 word/cycle while src_ready=1.
  - Never more than 2 words buffered or in flight.
  - After the last issue -> RD_DRAIN.
- RD_DRAIN: wait until the FIFO is empty and inflight = 0, then -> DONE.
- src rules:
  - src_valid = FIFO not empty; a beat transfers when src_valid & src_ready.
  - src_data and src_valid stay stable while src_valid=1 and src_ready=0.
  - Word order equals address order.
- WR_RUN:
  - snk_ready = 1 while remaining > 0.
  - A beat accepted in cycle t produces mem write in t+1: chipselect=1, write=1, registered address and writedata.
  - Throughput 1 word/cycle.
  - On acceptance of the final beat -> WR_LAST.
- WR_LAST: final write is on the bus this cycle -> DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then -> IDLE. A start in the DONE cycle is ignored.
- mem_chipselect is 0 in every cycle without an access; mem_write is 0 whenever mem_chipselect is 0.
- Reset mid-operation: the transfer is aborted and buffered data is discarded; the next start behaves normally.

Optional Feature:
- Macro: SOPC_BE_MSM_CSUM_EN.
- Defined:
  - csum is a 32-bit modulo-2^32 sum of every word transferred (src beats in read mode, accepted snk beats in write mode).
  - Cleared on start acceptance; final value holds from the DONE cycle until the next start.
- Undefined: csum is tied to 0 and no adder logic is present.

Test Plan:
- Mem[0..3]=0x11,0x22,0x33,0x44; read base=0 length=4, src_ready=1 -> src beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles; done pulses once after the last beat; mem_write never 1.
- Write base=9998 length=4, snk beats 0xA0..0xA3 back-to-back -> writes to addresses 9998,9999,0,1 with data 0xA0..0xA3; byteenable 0xF.
- Read base=100 length=6 with src_ready low for 5 cycles mid-block -> all 6 words in order; at most 2 buffered or in flight; src_data stable while stalled.
- start with length=0 -> IDLE->DONE->IDLE; done high 1 cycle; chipselect never asserted. start pulsed while busy -> ignored.
- reset_n low 2 cycles during a read at word 3 of 8 -> all outputs reset immediately; subsequent read base=0 length=2 completes correctly.
- With SOPC_BE_MSM_CSUM_EN defined, write 1,2,3,0xFFFFFFFF -> csum=0x00000005 at done.

Source files
------------

// File: rtl/sopc_be_mem_stream_master.sv
// rtl/sopc_be_mem_stream_master.sv - memory-mapped block mover between on-chip memory and valid/ready streams
// Optional running checksum of transferred words: SOPC_BE_MSM_CSUM_EN
module sopc_be_mem_stream_master #(
  parameter int DEPTH  = 10000,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready,
  input  logic [DATA_W-1:0]   snk_data,
  input  logic                snk_valid,
  output logic                snk_ready,
  output logic [31:0]         csum
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD_RUN, S_RD_DRAIN, S_WR_RUN, S_WR_LAST, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic                wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                inflight_q, inflight_d;
  logic [DATA_W-1:0]   fifo_q [2];
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          cnt_q, cnt_d;
  logic                clken_q;

  logic                push, pop, rd_issue, accept;
  logic [1:0]          occ;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_A) ? '0 : a + ADDR_W'(1);
  endfunction

  // Read-path handshakes: a word returns the cycle after issue; keep words buffered plus in flight at most two
  always_comb begin
    push     = inflight_q;
    pop      = (cnt_q != 2'd0) && src_ready;
    occ      = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    rd_issue = (state_q == S_RD_RUN) && (rem_q != '0) && (occ < 2'd2);
    accept   = snk_valid && snk_ready;
  end

  // Next-state and datapath updates for the command sequencer
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    wr_pend_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    inflight_d = rd_issue;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = (base_addr >= DEPTH_A) ? '0 : base_addr;
          rem_d  = (length > DEPTH_A) ? DEPTH_A : length;
          if (length == '0)  state_d = S_DONE;
          else if (mode)     state_d = S_WR_RUN;
          else               state_d = S_RD_RUN;
        end
      end
      S_RD_RUN: begin
        if (rd_issue) begin
          addr_d = addr_inc(addr_q);
          rem_d  = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) state_d = S_RD_DRAIN;
        end
      end
      S_RD_DRAIN: begin
        if ((cnt_d == 2'd0) && !inflight_q) state_d = S_DONE;
      end
      S_WR_RUN: begin
        if (accept) begin
          wr_pend_d = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = snk_data;
          addr_d    = addr_inc(addr_q);
          rem_d     = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) state_d = S_WR_LAST;
        end
      end
      S_WR_LAST: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Sequencer, address and write-stage registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      inflight_q <= 1'b0;
      clken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      inflight_q <= inflight_d;
      clken_q    <= 1'b1;
    end
  end

  // Two-entry read-data FIFO feeding the source port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_readdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign mem_chipselect = rd_issue || wr_pend_q;
  assign mem_write      = wr_pend_q;
  assign mem_address    = wr_pend_q ? wr_addr_q : addr_q;
  assign mem_writedata  = wr_data_q;
  assign mem_byteenable = '1;
  assign mem_clken      = clken_q;
  assign src_valid      = (cnt_q != 2'd0);
  assign src_data       = fifo_q[rd_ptr_q];
  assign snk_ready      = (state_q == S_WR_RUN) && (rem_q != '0);

`ifdef SOPC_BE_MSM_CSUM_EN
  logic [31:0] csum_q;

  // Running sum of every transferred word, restarted when a command is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q + 32'(src_data);
    end else if (accept) begin
      csum_q <= csum_q + 32'(snk_data);
    end
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_sopc_be_mem_stream_master.sv
// tb/tb_sopc_be_mem_stream_master.sv - scoreboard bench for sopc_be_mem_stream_master
module tb_sopc_be_mem_stream_master;
  localparam int DEPTH = 10000;
  localparam int AW    = 14;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, mode;
  logic [AW-1:0] base_addr, length;
  logic          busy, done;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [3:0]    mem_byteenable;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic [DW-1:0] src_data, snk_data;
  logic          src_valid, src_ready, snk_valid, snk_ready;
  logic [31:0]   csum;

  always #5 clk = ~clk;

  sopc_be_mem_stream_master #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .snk_data(snk_data), .snk_valid(snk_valid),
    .snk_ready(snk_ready), .csum(csum)
  );

  // memory slave model, read latency 1
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rdata_q = '0;
  always @(posedge clk) begin
    if (mem_chipselect && !mem_write) rdata_q <= mem[mem_address];
    if (mem_chipselect && mem_write)  mem[mem_address] = mem_writedata;
  end
  assign mem_readdata = rdata_q;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  logic [DW-1:0] rd_exp [$];
  wr_t           wr_exp [$];
  logic [DW-1:0] snk_q  [$];

  int   cyc = 0, beats = 0, outst = 0, done_cnt = 0, cs_cnt = 0;
  int   gap_cnt = 0, last_pop_cyc = -10;
  logic stall_prev = 1'b0, done_prev = 1'b0, snk_fire = 1'b0;
  logic [DW-1:0] stall_data = '0;

  // monitor: compares DUT activity against scoreboard queues
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (!reset_n) begin
      outst = 0; stall_prev = 1'b0; done_prev = 1'b0; snk_fire = 1'b0;
    end else begin
      if (mem_chipselect && !mem_write) outst++;
      if (src_valid && src_ready) begin
        outst--;
        beats++;
        if (last_pop_cyc >= 0 && cyc != last_pop_cyc + 1) gap_cnt++;
        last_pop_cyc = cyc;
        if (rd_exp.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL src_extra: got beat 0x%08h expected none", src_data);
        end else check("src_data", src_data, rd_exp.pop_front());
      end
      if (mem_chipselect && !mem_write) check("outstanding_gt2", 32'(outst > 2), 32'd0);
      if (mem_chipselect && mem_write) begin
        if (wr_exp.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL wr_extra: got write 0x%08h at %0d expected none", mem_writedata, mem_address);
        end else begin
          e = wr_exp.pop_front();
          check("wr_addr", 32'(mem_address), 32'(e.a));
          check("wr_data", mem_writedata, e.d);
          check("byteenable", 32'(mem_byteenable), 32'hF);
        end
      end
      if (mem_write && !mem_chipselect) check("write_without_cs", 32'(mem_write), 32'd0);
      if (stall_prev) begin
        check("stall_valid", 32'(src_valid), 32'd1);
        check("stall_data", src_data, stall_data);
      end
      stall_prev = src_valid && !src_ready;
      stall_data = src_data;
      if (done) begin
        done_cnt++;
        check("busy_in_done", 32'(busy), 32'd0);
        if (done_prev) check("done_width", 32'(done_prev), 32'd0);
      end
      done_prev = done;
      if (mem_chipselect) cs_cnt++;
      snk_fire = snk_valid && snk_ready;
    end
  end

  // sink driver: presents queued beats, advances on each accepted beat
  initial begin
    snk_valid = 1'b0;
    snk_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (snk_fire && snk_q.size() > 0) snk_q.delete(0);
      snk_valid = (snk_q.size() > 0);
      snk_data  = (snk_q.size() > 0) ? snk_q[0] : '0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_cmd(input logic m, input logic [AW-1:0] b, input logic [AW-1:0] l);
    int d0, k;
    d0 = done_cnt;
    mode = m; base_addr = b; length = l; start = 1'b1;
    step();
    start = 1'b0;
    if (l != '0) check("busy_after_start", 32'(busy), 32'd1);
    k = 0;
    while (done_cnt == d0 && k < 400) begin step(); k++; end
    step(); step();
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("rd_exp_left", 32'(rd_exp.size()), 32'd0);
    check("wr_exp_left", 32'(wr_exp.size()), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_write", 32'(mem_write), 32'd0);
    check("rst_clken", 32'(mem_clken), 32'd0);
    check("rst_be", 32'(mem_byteenable), 32'hF);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_src_valid", 32'(src_valid), 32'd0);
    check("rst_src_data", src_data, 32'd0);
    check("rst_snk_ready", 32'(snk_ready), 32'd0);
    check("rst_csum", csum, 32'd0);
  endtask

  initial begin
    int d0, c0, b0, k;
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0; length = '0; src_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    for (int i = 0; i < 6; i++) mem[100 + i] = 32'h100 + 32'(i);
    step(); step();
    check_reset_outputs();
    reset_n = 1'b1;
    step();
    check("clken_after_release", 32'(mem_clken), 32'd1);

    // read 4 words from 0
    rd_exp.push_back(32'h11); rd_exp.push_back(32'h22);
    rd_exp.push_back(32'h33); rd_exp.push_back(32'h44);
    gap_cnt = 0; last_pop_cyc = -10;
    run_cmd(1'b0, 14'd0, 14'd4);
    check("read_gaps", 32'(gap_cnt), 32'd0);
`ifndef SOPC_BE_MSM_CSUM_EN
    check("csum_tied_zero", csum, 32'd0);
`endif

    // write 4 words wrapping the top of memory
    for (int i = 0; i < 4; i++) snk_q.push_back(32'hA0 + 32'(i));
    wr_exp.push_back({14'd9998, 32'hA0}); wr_exp.push_back({14'd9999, 32'hA1});
    wr_exp.push_back({14'd0,    32'hA2}); wr_exp.push_back({14'd1,    32'hA3});
    run_cmd(1'b1, 14'd9998, 14'd4);
    check("mem9999", mem[9999], 32'hA1);
    check("mem1", mem[1], 32'hA3);

    // read 6 with a 5-cycle stall and an ignored start while busy
    for (int i = 0; i < 6; i++) rd_exp.push_back(32'h100 + 32'(i));
    fork
      run_cmd(1'b0, 14'd100, 14'd6);
      begin
        repeat (4) step();
        src_ready = 1'b0;
        mode = 1'b1; length = 14'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        src_ready = 1'b1;
      end
    join

    // out-of-range base reads from 0
    rd_exp.push_back(32'hA2);
    run_cmd(1'b0, 14'd12000, 14'd1);

    // zero length, start held into the DONE cycle
    d0 = done_cnt; c0 = cs_cnt;
    mode = 1'b0; base_addr = 14'd5; length = 14'd0; start = 1'b1;
    step();
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    check("len0_back_idle", 32'(done), 32'd0);
    step(); step();
    check("len0_done_count", 32'(done_cnt - d0), 32'd1);
    check("len0_no_cs", 32'(cs_cnt - c0), 32'd0);

    // reset during a read of 8 after 3 beats
    rd_exp.push_back(32'hA2); rd_exp.push_back(32'hA3);
    rd_exp.push_back(32'h33); rd_exp.push_back(32'h44);
    for (int i = 0; i < 4; i++) rd_exp.push_back(32'h0);
    b0 = beats;
    mode = 1'b0; base_addr = 14'd0; length = 14'd8; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (beats < b0 + 3 && k < 100) begin step(); k++; end
    check("beats_before_reset", 32'(beats - b0 >= 3), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    rd_exp.delete();
    step(); step();
    reset_n = 1'b1;
    step();
    check("clken_after_rerelease", 32'(mem_clken), 32'd1);
    rd_exp.push_back(32'hA2); rd_exp.push_back(32'hA3);
    run_cmd(1'b0, 14'd0, 14'd2);

`ifdef SOPC_BE_MSM_CSUM_EN
    snk_q.push_back(32'd1); snk_q.push_back(32'd2);
    snk_q.push_back(32'd3); snk_q.push_back(32'hFFFF_FFFF);
    wr_exp.push_back({14'd300, 32'd1}); wr_exp.push_back({14'd301, 32'd2});
    wr_exp.push_back({14'd302, 32'd3}); wr_exp.push_back({14'd303, 32'hFFFF_FFFF});
    run_cmd(1'b1, 14'd300, 14'd4);
    check("csum_write", csum, 32'h0000_0005);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
